// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Wait-stated data-memory responder for the processor's data bus. It accepts
// one load/store request at a time over a req/ack handshake. It stalls the
// processor for WAIT_CYCLES cycles, then performs a word access into a local
// RAM. Misaligned or out-of-range accesses are flagged with o_err_w.
//
// Parameters
//   DEPTH_LOG2  : the RAM holds 2^DEPTH_LOG2 32-bit words (keep <= 29)
//   WAIT_CYCLES : wait cycles inserted before ack (0..15)
//
// Ports
//   i_clk_w   : clock, rising edge
//   i_rst_w   : asynchronous active-high reset
//   i_req_w   : request valid, held by the initiator until it sees o_ack_w
//   i_we_w    : 1 = store, 0 = load
//   i_a_w     : byte address
//   i_wd_w    : store data
//   o_rd_w    : load data (registered), valid while o_ack_w = 1
//   o_ack_w   : one-cycle completion pulse (registered)
//   o_err_w   : access error (registered), only ever high together with ack
//   o_busy_w  : combinational stall to the processor
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH_LOG2  = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        i_clk_w,
  input  logic        i_rst_w,
  input  logic        i_req_w,
  input  logic        i_we_w,
  input  logic [31:0] i_a_w,
  input  logic [31:0] i_wd_w,
  output logic [31:0] o_rd_w,
  output logic        o_ack_w,
  output logic        o_err_w,
  output logic        o_busy_w
);

  localparam int         DEPTH    = 2 ** DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        w_accept;

  logic [31:0] r_a;
  logic        r_we;
  logic [31:0] r_wd;

  logic [31:0] r_mem [DEPTH];

  logic [31:0]           w_acc_a;
  logic                  w_acc_we;
  logic [31:0]           w_acc_wd;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_err;
  logic                  w_access;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default before the case, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req_w) begin
          w_accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_state_nxt = ST_ACK;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_state_nxt = ST_ACK;
        end
      end
      ST_ACK:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The access happens on the edge that enters ACK. With zero wait cycles that
  // edge is also the accepting edge, so the request comes straight from the
  // inputs. Otherwise it comes from the values latched at acceptance.
  always_comb begin
    w_acc_a  = r_a;
    w_acc_we = r_we;
    w_acc_wd = r_wd;
    if (r_state == ST_IDLE) begin
      w_acc_a  = i_a_w;
      w_acc_we = i_we_w;
      w_acc_wd = i_wd_w;
    end
  end

  assign w_access = (r_state != ST_ACK) && (w_state_nxt == ST_ACK);
  assign w_idx    = w_acc_a[DEPTH_LOG2+1:2];
  assign w_err    = (w_acc_a[1:0] != 2'b00) || ((w_acc_a >> (DEPTH_LOG2 + 2)) != 32'd0);

  assign o_busy_w = ((r_state == ST_IDLE) && i_req_w) || (r_state == ST_WAIT);

  // ---------------------------------------------------------------------------
  // Control and response registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so that every register
  // samples pre-edge values, whatever order the blocks are evaluated in.
  always_ff @(posedge i_clk_w or posedge i_rst_w) begin
    if (i_rst_w) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_a     <= 32'd0;
      r_we    <= 1'b0;
      r_wd    <= 32'd0;
      o_ack_w <= 1'b0;
      o_err_w <= 1'b0;
      o_rd_w  <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_a  <= i_a_w;
        r_we <= i_we_w;
        r_wd <= i_wd_w;
      end
      o_ack_w <= w_access;
      o_err_w <= w_access && w_err;
      if (w_access) begin
        if (w_err)         o_rd_w <= 32'd0;
        else if (w_acc_we) o_rd_w <= w_acc_wd;  // write-through read data
        else               o_rd_w <= r_mem[w_idx];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // RAM
  // ---------------------------------------------------------------------------
  // NOTE: the RAM array has no reset so it maps onto block memory. Reset still
  // gates the write enable, so no store lands while reset is held.
  always_ff @(posedge i_clk_w) begin
    if (w_access && w_acc_we && !w_err && !i_rst_w) begin
      r_mem[w_idx] <= w_acc_wd;
    end
  end

endmodule
